// File: rtl/nubus_pkg.sv
// Shared types and constants for the NuBus slave controller.
package nubus_pkg;

  // Transfer phases of the slave.
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StAck    = 2'b10
  } nubus_state_e;

  // Acknowledge status codes driven during the ack cycle.
  localparam logic [1:0] ST_COMPLETE = 2'b00;
  localparam logic [1:0] ST_ERROR    = 2'b01;
  localparam logic [1:0] ST_TRYAGAIN = 2'b11;

  // Transfer mode pin encodings (active-low pins).
  localparam logic TM1N_READ  = 1'b1;
  localparam logic TM1N_WRITE = 1'b0;

endpackage

// File: rtl/nubus_prio_onehot.sv
// Lowest-index-first priority select: returns a one-hot (or zero) grant vector.
module nubus_prio_onehot #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  logic found;

  // Walk upward and keep only the first set request bit.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nubus_slave_ctrl.sv
// NuBus slave controller: window decode latch, local valid/ready handshake,
// one-cycle acknowledge with complete / error / try-again status.
module nubus_slave_ctrl
  import nubus_pkg::*;
#(
  parameter int unsigned NUM_WIN     = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic               nub_clkn,
  input  logic               nub_reset,
  input  logic               nub_startn,
  input  logic               nub_ackn,
  input  logic               nub_tm1n,
  input  logic               nub_tm0n,
  input  logic [ADDR_W-1:0]  nub_ad,
  input  logic [NUM_WIN-1:0] win_hit,
  input  logic               mem_ready,
  input  logic               mem_err,
  output logic               slave_o,
  output logic [NUM_WIN-1:0] win_sel_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic               tm1n_o,
  output logic               tm0n_o,
  output logic               mem_valid_o,
  output logic               ackcy_o,
  output logic [1:0]         ack_stat_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  nubus_state_e state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_WIN-1:0] win_gnt;
  logic               start_ok;

  logic               slave_d, tm1n_d, tm0n_d, valid_d, ackcy_d;
  logic [NUM_WIN-1:0] win_sel_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [1:0]         stat_d;

  nubus_prio_onehot #(
    .N (NUM_WIN)
  ) u_prio (
    .req (win_hit),
    .gnt (win_gnt)
  );

  // Attention cycles (ACK low with START) and misses are not ours.
  assign start_ok = ~nub_startn & nub_ackn & (|win_hit);

  // Next-state and next-output decode; everything holds unless changed.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    slave_d   = slave_o;
    win_sel_d = win_sel_o;
    addr_d    = addr_o;
    tm1n_d    = tm1n_o;
    tm0n_d    = tm0n_o;
    valid_d   = mem_valid_o;
    ackcy_d   = ackcy_o;
    stat_d    = ack_stat_o;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d   = StAccess;
          addr_d    = nub_ad;
          tm1n_d    = nub_tm1n;
          tm0n_d    = nub_tm0n;
          win_sel_d = win_gnt;
          valid_d   = 1'b1;
          slave_d   = 1'b1;
          cnt_d     = '0;
        end
      end

      StAccess: begin
        // Error beats ready; ready beats timeout in the same cycle.
        if (mem_err || mem_ready || (cnt_q == CNT_LAST)) begin
          state_d = StAck;
          valid_d = 1'b0;
          ackcy_d = 1'b1;
          if (mem_err) begin
            stat_d = ST_ERROR;
          end else if (mem_ready) begin
            stat_d = ST_COMPLETE;
          end else begin
            stat_d = ST_TRYAGAIN;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      StAck: begin
        state_d = StIdle;
        slave_d = 1'b0;
        ackcy_d = 1'b0;
        stat_d  = ST_COMPLETE;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge nub_clkn) begin
    if (nub_reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      slave_o     <= 1'b0;
      win_sel_o   <= '0;
      addr_o      <= '0;
      tm1n_o      <= 1'b1;
      tm0n_o      <= 1'b1;
      mem_valid_o <= 1'b0;
      ackcy_o     <= 1'b0;
      ack_stat_o  <= ST_COMPLETE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slave_o     <= slave_d;
      win_sel_o   <= win_sel_d;
      addr_o      <= addr_d;
      tm1n_o      <= tm1n_d;
      tm0n_o      <= tm0n_d;
      mem_valid_o <= valid_d;
      ackcy_o     <= ackcy_d;
      ack_stat_o  <= stat_d;
    end
  end

endmodule

// File: tb/tb_nubus_slave_ctrl.sv
// Bench for nubus_slave_ctrl: directed scenarios plus random traffic,
// all checked against a transaction-level reference model.
module tb_nubus_slave_ctrl;
  import nubus_pkg::*;

  localparam int unsigned NW = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst, startn, ackn, tm1n, tm0n, ready, err;
  logic [AW-1:0] ad;
  logic [NW-1:0] hit;

  logic          slave_o, tm1n_o, tm0n_o, mem_valid_o, ackcy_o;
  logic [NW-1:0] win_sel_o;
  logic [AW-1:0] addr_o;
  logic [1:0]    ack_stat_o;

  always #5 clk = ~clk;

  nubus_slave_ctrl #(
    .NUM_WIN     (NW),
    .ADDR_W      (AW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .nub_clkn    (clk),
    .nub_reset   (rst),
    .nub_startn  (startn),
    .nub_ackn    (ackn),
    .nub_tm1n    (tm1n),
    .nub_tm0n    (tm0n),
    .nub_ad      (ad),
    .win_hit     (hit),
    .mem_ready   (ready),
    .mem_err     (err),
    .slave_o     (slave_o),
    .win_sel_o   (win_sel_o),
    .addr_o      (addr_o),
    .tm1n_o      (tm1n_o),
    .tm0n_o      (tm0n_o),
    .mem_valid_o (mem_valid_o),
    .ackcy_o     (ackcy_o),
    .ack_stat_o  (ack_stat_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: whether a transfer is waiting on the local side, whether
  // the ack is on the bus, how many cycles it has waited, and the outputs.
  bit            m_waiting, m_acking;
  int            m_waited;
  logic          m_slave, m_tm1, m_tm0, m_valid, m_ackcy;
  logic [NW-1:0] m_win;
  logic [AW-1:0] m_addr;
  logic [1:0]    m_stat;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NW-1:0] lowest_bit(input logic [NW-1:0] v);
    logic [NW-1:0] one;
    one = 1;
    return v & (~v + one);
  endfunction

  task automatic model_reset();
    m_waiting = 0; m_acking = 0; m_waited = 0;
    m_slave = 0; m_win = '0; m_addr = '0; m_tm1 = 1; m_tm0 = 1;
    m_valid = 0; m_ackcy = 0; m_stat = ST_COMPLETE;
  endtask

  task automatic finish_access(input logic [1:0] st);
    m_waiting = 0; m_acking = 1; m_valid = 0; m_ackcy = 1; m_stat = st;
  endtask

  // Apply the rules for one clock edge using the inputs present at that edge.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (m_acking) begin
      m_acking = 0; m_slave = 0; m_ackcy = 0; m_stat = ST_COMPLETE;
    end else if (m_waiting) begin
      if (err)                      finish_access(ST_ERROR);
      else if (ready)               finish_access(ST_COMPLETE);
      else if (m_waited + 1 == TO)  finish_access(ST_TRYAGAIN);
      else                          m_waited++;
    end else if (!startn && ackn && hit != '0) begin
      m_waiting = 1; m_waited = 0;
      m_addr = ad; m_tm1 = tm1n; m_tm0 = tm0n; m_win = lowest_bit(hit);
      m_valid = 1; m_slave = 1;
    end
  endtask

  task automatic check_all();
    check_eq("slave",   slave_o,     m_slave);
    check_eq("win_sel", win_sel_o,   m_win);
    check_eq("addr",    addr_o,      m_addr);
    check_eq("tm1n",    tm1n_o,      m_tm1);
    check_eq("tm0n",    tm0n_o,      m_tm0);
    check_eq("valid",   mem_valid_o, m_valid);
    check_eq("ackcy",   ackcy_o,     m_ackcy);
    check_eq("stat",    ack_stat_o,  m_stat);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic quiet();
    rst = 0; startn = 1; ackn = 1; hit = '0; ready = 0; err = 0;
  endtask

  task automatic do_reset();
    quiet(); rst = 1; cycle(); rst = 0;
  endtask

  task automatic start_xfer(input logic [NW-1:0] h, input logic [AW-1:0] a,
                            input logic t1, input logic t0);
    startn = 0; ackn = 1; hit = h; ad = a; tm1n = t1; tm0n = t0;
    cycle();
    startn = 1; hit = '0;
  endtask

  int valid_cnt;
  int lat;

  initial begin
    model_reset();
    quiet(); ad = '0; tm1n = 1; tm0n = 1;

    // Reset state.
    do_reset();
    check_eq("rst_tm1n", tm1n_o, 1'b1);
    check_eq("rst_slave", slave_o, 1'b0);

    // Read, ready three cycles after the start.
    start_xfer(3'b010, 32'hF000_1234, TM1N_READ, 1'b1);
    valid_cnt = int'(mem_valid_o);
    cycle(); valid_cnt += int'(mem_valid_o);
    cycle(); valid_cnt += int'(mem_valid_o);
    ready = 1;
    cycle(); valid_cnt += int'(mem_valid_o);
    ready = 0;
    check_eq("rd_win", win_sel_o, 3'b010);
    check_eq("rd_addr", addr_o, 32'hF000_1234);
    check_eq("rd_valid_cycles", valid_cnt, 3);
    check_eq("rd_ack", ackcy_o, 1'b1);
    check_eq("rd_stat", ack_stat_o, ST_COMPLETE);
    cycle();
    check_eq("rd_ack_one_cycle", ackcy_o, 1'b0);

    // Dual hit write; error and ready together.
    start_xfer(3'b011, 32'h1234_5678, TM1N_WRITE, 1'b0);
    check_eq("wr_win", win_sel_o, 3'b001);
    check_eq("wr_tm1n", tm1n_o, TM1N_WRITE);
    err = 1; ready = 1;
    cycle();
    err = 0; ready = 0;
    check_eq("wr_stat", ack_stat_o, ST_ERROR);
    cycle();

    // Timeout: no response, bounded wait for the ack.
    start_xfer(3'b100, 32'hCAFE_0000, 1'b1, 1'b0);
    lat = 0;
    while (!ackcy_o && lat < 12) begin
      cycle(); lat++;
    end
    check_eq("to_latency", lat, TO);
    check_eq("to_stat", ack_stat_o, ST_TRYAGAIN);
    check_eq("to_valid", mem_valid_o, 1'b0);
    cycle();

    // Attention cycle and window miss after a fresh reset.
    do_reset();
    startn = 0; ackn = 0; hit = 3'b001; ad = 32'hDEAD_BEEF;
    cycle();
    check_eq("attn_slave", slave_o, 1'b0);
    startn = 0; ackn = 1; hit = '0;
    cycle();
    check_eq("miss_slave", slave_o, 1'b0);
    check_eq("miss_addr", addr_o, 32'h0);
    quiet();
    cycle();

    // Reset in the middle of an access, then an immediate new start.
    start_xfer(3'b001, 32'h0000_0ABC, 1'b0, 1'b1);
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    check_eq("mid_rst_valid", mem_valid_o, 1'b0);
    check_eq("mid_rst_addr", addr_o, 32'h0);
    start_xfer(3'b100, 32'h7777_0001, 1'b1, 1'b1);
    check_eq("post_rst_slave", slave_o, 1'b1);
    ready = 1; cycle(); ready = 0;
    cycle();

    // Back-to-back; a start during the access is ignored.
    start_xfer(3'b010, 32'hAAAA_0001, 1'b1, 1'b1);
    startn = 0; hit = 3'b001; ad = 32'hBBBB_0002;
    cycle();
    check_eq("b2b_ignored", addr_o, 32'hAAAA_0001);
    startn = 1; hit = '0; ready = 1;
    cycle();
    ready = 0;
    cycle();
    start_xfer(3'b001, 32'hCCCC_0003, 1'b0, 1'b0);
    check_eq("b2b_addr", addr_o, 32'hCCCC_0003);
    check_eq("b2b_win", win_sel_o, 3'b001);
    ready = 1; cycle(); ready = 0;
    cycle();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      rst    = ($urandom_range(0, 59) == 0);
      startn = ($urandom_range(0, 2) != 0);
      ackn   = ($urandom_range(0, 7) != 0);
      hit    = NW'($urandom);
      ad     = $urandom;
      tm1n   = 1'($urandom);
      tm0n   = 1'($urandom);
      ready  = ($urandom_range(0, 3) == 0);
      err    = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nubus_slave_ctrl.md
Name: nubus_slave_ctrl

Overview:
Parametrised NuBus slave controller; successor to the single-window slave state machine. Decodes a start cycle against NUM_WIN address windows (memory, ROM, registers, ...) and latches address, transfer mode and the selected window. Runs a valid/ready handshake to the local memory side and issues a one-cycle NuBus acknowledge carrying a status code: complete, error, or try-again after timeout. Sits between the NuBus pin interface and the card's local memory/register mux.

Parameters:
NUM_WIN, 2, number of address windows; win_hit/win_sel width
ADDR_W, 32, latched address width (NuBus AD)
TIMEOUT_CYC, 255, ACCESS cycles before forced try-again; must be >=1
CNT_W, $clog2(TIMEOUT_CYC+1), timeout counter width (derived)

Ports:
nub_clkn  in  1  NuBus clock; all logic on rising edge
nub_reset  in  1  synchronous, active-high reset
nub_startn  in  1  NuBus START, active low
nub_ackn  in  1  NuBus ACK, active low
nub_tm1n  in  1  transfer mode 1 (1 = read)
nub_tm0n  in  1  transfer mode 0
nub_ad  in  ADDR_W  address/data bus, sampled on start cycle
win_hit  in  NUM_WIN  external window decode of nub_ad, valid on start cycle
mem_ready  in  1  local side completes access
mem_err  in  1  local side rejects access
slave_o  out  1  transfer owned by this slave
win_sel_o  out  NUM_WIN  latched one-hot selected window
addr_o  out  ADDR_W  latched address
tm1n_o  out  1  latched tm1n
tm0n_o  out  1  latched tm0n
mem_valid_o  out  1  request to local side
ackcy_o  out  1  acknowledge cycle; drives ACK and status onto bus
ack_stat_o  out  2  status during ackcy_o: 00 complete, 01 error, 11 try-again

Behaviour:
- Reset (nub_reset=1 at clock edge): state IDLE; slave_o=0, win_sel_o=0, addr_o=0, tm1n_o=1, tm0n_o=1, mem_valid_o=0, ackcy_o=0, ack_stat_o=00, counter=0. Reset mid-transfer aborts silently; no ack is issued.
- States: IDLE, ACCESS, ACK.
- IDLE -> ACCESS when start=~nub_startn=1, nub_ackn=1, and |win_hit. On that edge: latch addr_o=nub_ad, tm1n_o/tm0n_o from pins, and win_sel_o = lowest-index set bit of win_hit (strict priority, always one-hot). Also set mem_valid_o=1, slave_o=1, counter=0.
- Start with nub_ackn=0 (attention cycle) or win_hit=0: ignored; stay IDLE.
- ACCESS: mem_valid_o held at 1; counter increments each cycle, saturating.
  - mem_err=1 -> ACK with stat 01. mem_err has priority over mem_ready in the same cycle.
  - else mem_ready=1 -> ACK with stat 00.
  - else counter==TIMEOUT_CYC-1 -> ACK with stat 11. A ready arriving in the same cycle wins.
  - On the transition edge mem_valid_o drops to 0. Latency: ready sampled at edge N gives ackcy_o=1 from edge N to edge N+1.
- ACK: exactly one cycle; ackcy_o=1, ack_stat_o valid, slave_o=1. Then -> IDLE: slave_o=0, ackcy_o=0, ack_stat_o=00. win_sel_o, addr_o, tm*_o hold until the next accepted start.
- START seen in ACCESS or ACK (protocol violation) is ignored; the transfer continues.
- In IDLE, mem_ready and mem_err are don't-care.

Decomposition:
- Shared package nubus_pkg: state enum (IDLE/ACCESS/ACK), ack status constants (ST_COMPLETE=2'b00, ST_ERROR=2'b01, ST_TRYAGAIN=2'b11), TM encodings.
- One natural sub-module: nubus_prio_onehot (parametrised lowest-index-first one-hot priority select for win_hit).
- The timeout counter stays inline.

Test Plan:
- Reset then read: start, tm1n=1, win_hit=2'b10, ad=32'hF0001234; mem_ready 3 cycles later -> win_sel_o=2'b10, addr_o=F0001234, mem_valid_o high 3 cycles, one ackcy_o cycle, stat 00.
- Dual hit, write: win_hit=2'b11, tm1n=0 -> win_sel_o=2'b01, tm1n_o=0; mem_err and mem_ready together -> stat 01.
- Timeout with TIMEOUT_CYC=4, no ready -> ackcy_o asserted after exactly 4 ACCESS cycles, stat 11, mem_valid_o low from the ack edge.
- Attention cycle (start with ackn=0) and start with win_hit=0 -> no state change, all outputs at reset values.
- Reset mid-ACCESS -> next cycle all outputs at reset values; no ackcy_o ever; a new start is accepted right after reset drops.
- Back-to-back: new start in the cycle after ACK -> accepted with fresh latches; a start during ACCESS is ignored.
